// File: rtl/execute_stage.sv
// RV32I execute stage: ALU, address generation, branch/jump resolution, one registered output stage.
// Latency 1 cycle; stall holds every output register, flush (or no valid input) loads a bubble and wins over stall.
module execute_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic        rd_en,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    output logic        out_valid,
    output logic [31:0] alu_result,
    output logic [31:0] store_data,
    output logic [4:0]  rd_out,
    output logic        rd_en_out,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [2:0]  mem_funct3,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        illegal,
    output logic        ecall
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BCC   = 7'b1100011;
    localparam logic [6:0] OP_LCC   = 7'b0000011;
    localparam logic [6:0] OP_SCC   = 7'b0100011;
    localparam logic [6:0] OP_MCC   = 7'b0010011;
    localparam logic [6:0] OP_RCC   = 7'b0110011;
    localparam logic [6:0] OP_CCC   = 7'b1110011;

    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_out;
    logic        br_cond;
    logic [31:0] pc_plus_imm;
    logic [31:0] pc_plus_4;
    logic [31:0] rs1_plus_imm;

    logic [31:0] ex_result;
    logic [31:0] ex_target;
    logic        ex_illegal;
    logic        ex_ecall;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_br;

    logic        out_valid_q,  out_valid_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] store_data_q, store_data_d;
    logic [4:0]  rd_out_q,     rd_out_d;
    logic        rd_en_out_q,  rd_en_out_d;
    logic        mem_rd_q,     mem_rd_d;
    logic        mem_wr_q,     mem_wr_d;
    logic [2:0]  mem_funct3_q, mem_funct3_d;
    logic        br_taken_q,   br_taken_d;
    logic [31:0] br_target_q,  br_target_d;
    logic        illegal_q,    illegal_d;
    logic        ecall_q,      ecall_d;

    assign pc_plus_imm  = pc + imm;
    assign pc_plus_4    = pc + 32'd4;
    assign rs1_plus_imm = rs1_data + imm;

    always_comb begin
        op_b    = (opcode == OP_RCC) ? rs2_data : imm;
        shamt   = op_b[4:0];
        alu_out = 32'h0;
        case (funct3)
            3'b000: alu_out = (opcode == OP_RCC && funct7[5]) ? rs1_data - op_b : rs1_data + op_b;
            3'b001: alu_out = rs1_data << shamt;
            3'b010: alu_out = {31'h0, $signed(rs1_data) < $signed(op_b)};
            3'b011: alu_out = {31'h0, rs1_data < op_b};
            3'b100: alu_out = rs1_data ^ op_b;
            3'b101: alu_out = funct7[5] ? 32'($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
            3'b110: alu_out = rs1_data | op_b;
            default: alu_out = rs1_data & op_b;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000: br_cond = (rs1_data == rs2_data);
            3'b001: br_cond = (rs1_data != rs2_data);
            3'b100: br_cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101: br_cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110: br_cond = (rs1_data <  rs2_data);
            3'b111: br_cond = (rs1_data >= rs2_data);
            default: br_cond = 1'b0;
        endcase
    end

    // Illegal and ecall leave result, memory and branch controls at zero.
    always_comb begin
        ex_result  = 32'h0;
        ex_target  = pc_plus_imm;
        ex_illegal = 1'b0;
        ex_ecall   = 1'b0;
        ex_mem_rd  = 1'b0;
        ex_mem_wr  = 1'b0;
        ex_br      = 1'b0;
        case (opcode)
            OP_LUI:   ex_result = imm;
            OP_AUIPC: ex_result = pc_plus_imm;
            OP_JAL: begin
                ex_result = pc_plus_4;
                ex_br     = 1'b1;
            end
            OP_JALR: begin
                if (funct3 != 3'b000) begin
                    ex_illegal = 1'b1;
                end else begin
                    ex_result = pc_plus_4;
                    ex_br     = 1'b1;
                    ex_target = {rs1_plus_imm[31:1], 1'b0};
                end
            end
            OP_BCC: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) ex_illegal = 1'b1;
                else                                      ex_br      = br_cond;
            end
            OP_LCC: begin
                ex_result = rs1_plus_imm;
                ex_mem_rd = 1'b1;
            end
            OP_SCC: begin
                ex_result = rs1_plus_imm;
                ex_mem_wr = 1'b1;
            end
            OP_MCC: begin
                if ((funct3 == 3'b001 && funct7 != 7'h00) ||
                    (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20))
                    ex_illegal = 1'b1;
                else
                    ex_result = alu_out;
            end
            OP_RCC: begin
                if (funct7 == 7'h00 ||
                    (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    ex_result = alu_out;
                else
                    ex_illegal = 1'b1;
            end
            OP_CCC: begin
                if (funct3 == 3'b000 && rd == 5'd0 && imm == 32'h0 && funct7 == 7'h00)
                    ex_ecall = 1'b1;
                else
                    ex_illegal = 1'b1;
            end
            default: ex_illegal = 1'b1;
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        rd_out_d     = rd_out_q;
        rd_en_out_d  = rd_en_out_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        mem_funct3_d = mem_funct3_q;
        br_taken_d   = br_taken_q;
        br_target_d  = br_target_q;
        illegal_d    = illegal_q;
        ecall_d      = ecall_q;
        if (flush || (!stall && !in_valid)) begin
            // Bubble: clear control, leave data registers as they were.
            out_valid_d = 1'b0;
            rd_en_out_d = 1'b0;
            mem_rd_d    = 1'b0;
            mem_wr_d    = 1'b0;
            br_taken_d  = 1'b0;
            illegal_d   = 1'b0;
            ecall_d     = 1'b0;
        end else if (!stall) begin
            out_valid_d  = 1'b1;
            alu_result_d = ex_result;
            store_data_d = rs2_data;
            rd_out_d     = rd;
            rd_en_out_d  = rd_en && !ex_illegal && !ex_ecall;
            mem_rd_d     = ex_mem_rd;
            mem_wr_d     = ex_mem_wr;
            mem_funct3_d = funct3;
            br_taken_d   = ex_br;
            br_target_d  = ex_target;
            illegal_d    = ex_illegal;
            ecall_d      = ex_ecall;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            alu_result_q <= 32'h0;
            store_data_q <= 32'h0;
            rd_out_q     <= 5'd0;
            rd_en_out_q  <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_funct3_q <= 3'd0;
            br_taken_q   <= 1'b0;
            br_target_q  <= 32'h0;
            illegal_q    <= 1'b0;
            ecall_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            rd_out_q     <= rd_out_d;
            rd_en_out_q  <= rd_en_out_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_funct3_q <= mem_funct3_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
            illegal_q    <= illegal_d;
            ecall_q      <= ecall_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_result = alu_result_q;
    assign store_data = store_data_q;
    assign rd_out     = rd_out_q;
    assign rd_en_out  = rd_en_out_q;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_funct3 = mem_funct3_q;
    assign br_taken   = br_taken_q;
    assign br_target  = br_target_q;
    assign illegal    = illegal_q;
    assign ecall      = ecall_q;

endmodule

// File: doc/execute_stage.md
# execute_stage

Registered execute stage that sits directly downstream of fetch/decode in the RV32I core. It consumes the decoded instruction fields plus register-file read data. It computes the ALU result, load/store address, branch/jump decision and redirect target, then presents them one cycle later to the memory/writeback stage. It supports stall (hold) and flush (bubble insertion) from the hazard logic.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  decoded instruction on inputs is valid this cycle.
- stall  in  1  hold all output registers unchanged.
- flush  in  1  discard current input; insert bubble.
- pc  in  32  address of the decoded instruction.
- opcode  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12].
- funct7  in  7  instruction[31:25].
- rd  in  5  destination register index.
- rd_en  in  1  instruction writes rd.
- rs1_data, rs2_data  in  32 each  register-file read values (already x0-forced to 0).
- imm  in  32  sign-extended immediate from decode.
- out_valid  out  1  outputs hold a valid executed instruction.
- alu_result  out  32  writeback value or memory address.
- store_data  out  32  rs2_data, passed through for SCC.
- rd_out  out  5  registered rd.
- rd_en_out  out  1  registered rd_en, gated as below.
- mem_rd, mem_wr  out  1 each  load / store request.
- mem_funct3  out  3  registered funct3 (access size/sign).
- br_taken  out  1  redirect fetch to br_target.
- br_target  out  32  redirect address.
- illegal  out  1  unrecognised opcode/funct combination.
- ecall  out  1  ECALL executed.

## Operation
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BCC 1100011, LCC 0000011, SCC 0100011, MCC 0010011, RCC 0110011, CCC 1110011.
- LUI: result = imm. AUIPC: result = pc+imm.
- JAL: result = pc+4; br_taken=1; target = pc+imm.
- JALR: result = pc+4; br_taken=1; target = (rs1_data+imm) & ~1. funct3≠000 → illegal.
- BCC: funct3 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. br_taken = comparison result; target = pc+imm; result = 0. funct3 010/011 → illegal.
- LCC: result = rs1_data+imm; mem_rd=1. SCC: result = rs1_data+imm; mem_wr=1.
- MCC: operand B = imm. RCC: operand B = rs2_data.
- ALU by funct3:
  - 000: ADD, or SUB only for RCC with funct7[5]=1.
  - 001: SLL.
  - 010: SLT (signed, result 1/0).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA when funct7[5]=1.
  - 110: OR.
  - 111: AND.
- Shift amount = operand B[4:0]. Other funct7 values on RCC/shifts → illegal.
- CCC with all of instruction[31:7] zero (funct3=0, rd=0, imm=0, rs1_data ignored): ecall=1. Any other CCC → illegal.
- Unknown opcode → illegal.
- Illegal/ecall instructions: rd_en_out=0, mem_rd=mem_wr=br_taken=0, result=0, out_valid=1.
- All arithmetic is modulo 2^32; overflow is ignored.

## Timing
- Latency 1 cycle: inputs sampled on edge N appear on outputs after edge N.
- Per edge, priority order:
  1. rst_n=0: every output = 0.
  2. flush=1: out_valid, rd_en_out, mem_rd, mem_wr, br_taken, illegal, ecall = 0; data outputs don't-care (hold).
  3. stall=1: all outputs hold.
  4. Otherwise: capture. in_valid=0 loads a bubble, identical to flush.
- flush overrides stall in the same cycle.
- br_taken is a single-cycle pulse per valid branch unless stall holds it. Upstream flushes the wrong-path instruction on the edge after br_taken is seen; this block does not self-flush.
- Reset asserted mid-stall clears outputs on that edge.

## Test plan
- Reset: rst_n=0 for 2 cycles with random inputs → all outputs 0; release with ADDI x1,x0,5 (imm=5, rs1_data=0) → next cycle out_valid=1, alu_result=5, rd_out=1, rd_en_out=1.
- ALU: RCC SUB, rs1=3, rs2=5 → alu_result=0xFFFFFFFE. SRA rs1=0x80000000, rs2=4 → 0xF8000000. SLTU rs1=1, rs2=0xFFFFFFFF → 1. SLT same operands → 0.
- Branch/jump: BLT pc=0x01000010, rs1=-1, rs2=1, imm=-8 → br_taken=1, br_target=0x01000008. BGEU same operands → br_taken=1. JALR rs1=0x01000021, imm=2, pc=0x01000000 → target 0x01000022, result 0x01000004.
- Memory: SW rs1=0x100, imm=-4, rs2=0xDEADBEEF → mem_wr=1, alu_result=0xFC, store_data=0xDEADBEEF, rd_en_out=0.
- Stall/flush: stall for 3 cycles after LUI imm=0x12345000 → outputs constant for 3 cycles. flush+stall together → out_valid=0 next edge.
- Illegal/ecall: opcode 1111111 → illegal=1, rd_en_out=0. Instruction 0x00000073 → ecall=1, out_valid=1.
